mux_rr_arbiter_4: RTL and testbench

- Round-robin arbiter and sequencer that shares one 4-to-1, 5-bit mux datapath between four requesters.
- Each requester presents a request and a 5-bit word.
- The block picks a winner, drives the mux select, and registers the selected word.
- It presents the word downstream with a valid/ready handshake.
- It sits between the four producer ports and the single downstream consumer of the mux output.

---
 rtl/mux_arb_pkg.sv | 10 +
 rtl/rr_pick4.sv | 31 +++
 rtl/mux_rr_arbiter_4.sv | 51 +++++
 tb/tb_mux_rr_arbiter_4.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, FSM state type and select helper for mux_rr_arbiter_4
package mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;
  localparam int DATA_W = 5;
  typedef enum logic {IDLE, BUSY} state_t;
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational winner picker, round-robin after last_grant (fixed priority 0..3 under MUX_ARB_FIXED_PRIO_EN)
module rr_pick4
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [SEL_W-1:0] grant_idx,
  output logic             any
);
`ifdef MUX_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;
`endif
  // Walk the search order from lowest to highest priority so the highest-priority requester is written last
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx = '0;
    grant_onehot = '0;
    for (int k = N_REQ; k >= 1; k--) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      idx = SEL_W'(k - 1);
`else
      idx = SEL_W'(int'(last_grant) + k);
`endif
      grant_onehot = req[idx] ? N_REQ'(1) << idx : grant_onehot;
    end
  end
  assign grant_idx = onehot_to_idx(grant_onehot);
  assign any = |req;
endmodule

// File: rtl/mux_rr_arbiter_4.sv
// mux_rr_arbiter_4: round-robin arbiter sharing one 4:1 mux with a registered valid/ready output (MUX_ARB_FIXED_PRIO_EN selects fixed priority)
module mux_rr_arbiter_4
  import mux_arb_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] a,
  output logic [N_REQ-1:0]        req_ack,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);
  state_t            state;
  logic [SEL_W-1:0]  last_grant;
  logic [SEL_W-1:0]  grant_idx;
  logic [N_REQ-1:0]  grant_onehot;
  logic              any;
  logic              load;
  rr_pick4 u_pick (
    .req          (req),
    .last_grant   (last_grant),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (any)
  );
  assign load = (state == IDLE) || (out_valid && out_ready);
  assign req_ack = (load && !reset) ? grant_onehot : '0;
  // Output register loads the winner on every free slot; an empty handshake falls back to IDLE keeping data and sel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      sel        <= '0;
      last_grant <= SEL_W'(N_REQ - 1);
    end else if (load) begin
      if (any) begin
        out_data   <= a[grant_idx*DATA_W +: DATA_W];
        sel        <= grant_idx;
        last_grant <= grant_idx;
        out_valid  <= 1'b1;
        state      <= BUSY;
      end else begin
        out_valid  <= 1'b0;
        state      <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter_4.sv
// tb_mux_rr_arbiter_4: directed and random checks of mux_rr_arbiter_4 against a search-order reference model
module tb_mux_rr_arbiter_4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req = '0;
  logic [19:0] a = '0;
  logic [3:0]  req_ack;
  logic [1:0]  sel;
  logic [4:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  logic       m_valid;
  logic [4:0] m_data;
  int         m_sel;
  int         m_lg;

  mux_rr_arbiter_4 dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a         (a),
    .req_ack   (req_ack),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  function automatic int winner(input logic [3:0] r, input int lg);
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 4; k++) if (r[k]) return k;
`else
    for (int k = 1; k <= 4; k++) if (r[(lg + k) % 4]) return (lg + k) % 4;
`endif
    return -1;
  endfunction

  function automatic logic [3:0] model_ack();
    int w;
    w = winner(req, m_lg);
    if (reset || (m_valid && !out_ready) || w < 0) return 4'b0000;
    return 4'(1 << w);
  endfunction

  // Reference model: one word slot, freed by handshake, filled by the first requester in search order
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sel   <= 0;
      m_lg    <= 3;
    end else if (!m_valid || out_ready) begin
      if (winner(req, m_lg) >= 0) begin
        m_valid <= 1'b1;
        m_data  <= a[winner(req, m_lg)*5 +: 5];
        m_sel   <= winner(req, m_lg);
        m_lg    <= winner(req, m_lg);
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    a = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = 4'b1111;
    a = 20'hfffff;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (out_data !== 5'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", out_data); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", req_ack); end
    do_reset();
  endtask

  task automatic test_single();
    @(negedge clk);
    req = 4'b0001;
    a = {15'h0, 5'h11};
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack got %b want 0001", req_ack); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_checks++; if (out_data !== 5'h11) begin n_fail++; $display("FAIL single_data got %h want 11", out_data); end
    n_checks++; if (sel !== 2'd0) begin n_fail++; $display("FAIL single_sel got %0d want 0", sel); end
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b want 0", out_valid); end
    n_checks++; if (out_data !== 5'h11) begin n_fail++; $display("FAIL single_keep got %h want 11", out_data); end
  endtask

  task automatic test_fairness();
    logic [1:0] exp_sel;
    do_reset();
    @(negedge clk);
    req = 4'b1111;
    a = {5'h04, 5'h03, 5'h02, 5'h01};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
      exp_sel = 2'd0;
`else
      exp_sel = 2'(k % 4);
`endif
      #1;
      n_checks++; if (req_ack !== 4'(1 << exp_sel)) begin n_fail++; $display("FAIL fair_ack[%0d] got %b want %b", k, req_ack, 4'(1 << exp_sel)); end
      @(posedge clk);
      #1;
      n_checks++; if (sel !== exp_sel) begin n_fail++; $display("FAIL fair_sel[%0d] got %0d want %0d", k, sel, exp_sel); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fair_valid[%0d] got %b want 1", k, out_valid); end
      n_checks++; if (out_data !== 5'(exp_sel + 1)) begin n_fail++; $display("FAIL fair_data[%0d] got %h want %h", k, out_data, 5'(exp_sel + 1)); end
      @(negedge clk);
    end
    req = 4'b0000;
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk);
    req = 4'b0100;
    a = {5'h00, 5'h15, 10'h0};
    out_ready = 1'b0;
    #1;
    n_checks++; if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL stall_first_ack got %b want 0100", req_ack); end
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL stall_ack[%0d] got %b want 0000", k, req_ack); end
      n_checks++; if (sel !== 2'd2 || out_data !== 5'h15 || out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold[%0d] got sel=%0d data=%h valid=%b want sel=2 data=15 valid=1", k, sel, out_data, out_valid); end
    end
    req = 4'b0000;
    out_ready = 1'b1;
    #1;
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL stall_release_ack got %b want 0000", req_ack); end
    @(posedge clk);
    #1;
    n_checks++; if (out_valid !== 1'b0 || sel !== 2'd2 || out_data !== 5'h15) begin n_fail++; $display("FAIL stall_drain got valid=%b sel=%0d data=%h want valid=0 sel=2 data=15", out_valid, sel, out_data); end
  endtask

  task automatic test_rotation();
    logic [1:0] exp_seq [3];
`ifdef MUX_ARB_FIXED_PRIO_EN
    exp_seq = '{2'd0, 2'd0, 2'd0};
`else
    exp_seq = '{2'd3, 2'd0, 2'd1};
`endif
    do_reset();
    @(negedge clk);
    req = 4'b0010;
    a = {5'h1d, 5'h1c, 5'h1b, 5'h1a};
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (sel !== 2'd1) begin n_fail++; $display("FAIL rot_prime got %0d want 1", sel); end
    @(negedge clk);
    req = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      n_checks++; if (sel !== exp_seq[k] || out_data !== 5'(5'h1a + exp_seq[k])) begin n_fail++; $display("FAIL rot_sel[%0d] got sel=%0d data=%h want sel=%0d", k, sel, out_data, exp_seq[k]); end
    end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    req = 4'b0001;
    a = {15'h0, 5'h07};
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #2;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", out_valid); end
    reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 5'h00 || sel !== 2'd0) begin n_fail++; $display("FAIL areset_now got valid=%b data=%h sel=%0d want 0/00/0", out_valid, out_data, sel); end
    n_checks++; if (req_ack !== 4'b0000) begin n_fail++; $display("FAIL areset_ack got %b want 0000", req_ack); end
    req = 4'b1111;
    out_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL areset_first_ack got %b want 0001", req_ack); end
    @(posedge clk);
    #1;
    n_checks++; if (sel !== 2'd0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_first_sel got sel=%0d valid=%b want 0/1", sel, out_valid); end
    @(negedge clk);
    req = 4'b0000;
  endtask

  task automatic test_random();
    logic [3:0] exp_ack;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      req = 4'($urandom);
      a = 20'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      #1;
      exp_ack = model_ack();
      n_checks++; if (req_ack !== exp_ack) begin n_fail++; $display("FAIL rand_ack[%0d] got %b want %b", k, req_ack, exp_ack); end
      n_checks++; if ($countones(req_ack) > 1) begin n_fail++; $display("FAIL rand_onehot[%0d] got %b want at most one bit", k, req_ack); end
      @(posedge clk);
      #1;
      n_checks++; if (out_valid !== m_valid || out_data !== m_data || sel !== 2'(m_sel)) begin n_fail++; $display("FAIL rand_out[%0d] got valid=%b data=%h sel=%0d want valid=%b data=%h sel=%0d", k, out_valid, out_data, sel, m_valid, m_data, m_sel); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_stall();
    test_rotation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
